// File: rtl/rr_bus_mux.sv
// Round-robin bus multiplexer: arbitrates NUM_SRC requesters onto one registered
// bus with valid/ready handshake, optional grant lock and a saturating transfer count.
module rr_bus_mux #(
    parameter int NUM_SRC    = 8,
    parameter int SEL_WIDTH  = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            req,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] data_in,
    input  logic                          lock,
    input  logic                          bus_ready,
    output logic [DATA_WIDTH-1:0]         bus_out,
    output logic                          bus_valid,
    output logic [NUM_SRC-1:0]            grant,
    output logic [SEL_WIDTH-1:0]          grant_idx,
    output logic [15:0]                   xfer_cnt
);

    localparam int CW = SEL_WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [SEL_WIDTH-1:0] ptr, ptr_next, rr_idx, sel_idx;
    logic [CW-1:0]        cand;
    logic                 rr_found, complete, keep_lock, load;

    assign complete  = (state == BUSY) && bus_ready;
    assign keep_lock = complete && lock && req[grant_idx];
    assign bus_valid = (state == BUSY);

    // Search starts at ptr and wraps at NUM_SRC, so non-power-of-two sizes never overrun.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(NUM_SRC)) begin
                cand = cand - CW'(NUM_SRC);
            end
            if (!rr_found && req[cand[SEL_WIDTH-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[SEL_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        sel_idx    = rr_idx;
        ptr_next   = ptr;
        if ((state == IDLE) || complete) begin
            if (keep_lock) begin
                // Locked regrant keeps the rotation point where it was.
                load       = 1'b1;
                sel_idx    = grant_idx;
                state_next = BUSY;
            end else if (rr_found) begin
                load       = 1'b1;
                sel_idx    = rr_idx;
                ptr_next   = (rr_idx == SEL_WIDTH'(NUM_SRC - 1)) ? '0 : rr_idx + 1'b1;
                state_next = BUSY;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            grant     <= '0;
            grant_idx <= '0;
            bus_out   <= '0;
            xfer_cnt  <= '0;
        end else begin
            ptr <= ptr_next;
            if (load) begin
                grant     <= NUM_SRC'(1) << sel_idx;
                grant_idx <= sel_idx;
                bus_out   <= data_in[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
            end else if (complete) begin
                grant <= '0;
            end
            if (complete && (xfer_cnt != 16'hFFFF)) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed bench for rr_bus_mux: reset, single transfer, rotation, stall, lock,
// asynchronous mid-transfer reset and counter saturation.
module tb_rr_bus_mux;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   req;
    logic [255:0] data_in;
    logic         lock;
    logic         bus_ready;
    logic [31:0]  bus_out;
    logic         bus_valid;
    logic [7:0]   grant;
    logic [2:0]   grant_idx;
    logic [15:0]  xfer_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    rr_bus_mux #(.NUM_SRC(8), .SEL_WIDTH(3), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .lock      (lock),
        .bus_ready (bus_ready),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] v);
        data_in[i*32 +: 32] = v;
    endtask

    // Reset pulse placed between edges, leaving the bench 4 time units after an edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] d0;
        rst_n     = 1'b0;
        req       = '0;
        data_in   = '0;
        lock      = 1'b0;
        bus_ready = 1'b0;
        #2;
        check("rst_valid", 32'(bus_valid), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_idx", 32'(grant_idx), 32'd0);
        check("rst_bus", bus_out, 32'd0);
        check("rst_cnt", 32'(xfer_cnt), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Single transfer from source 0
        set_data(0, 32'hA5A5_0001);
        req       = 8'h01;
        bus_ready = 1'b1;
        step();
        check("one_valid", 32'(bus_valid), 32'd1);
        check("one_bus", bus_out, 32'hA5A5_0001);
        check("one_grant", 32'(grant), 32'h01);
        check("one_idx", 32'(grant_idx), 32'd0);
        req = 8'h00;
        step();
        check("one_cnt", 32'(xfer_cnt), 32'd1);
        check("one_idle", 32'(bus_valid), 32'd0);
        check("one_grant0", 32'(grant), 32'h00);
        check("one_bus_hold", bus_out, 32'hA5A5_0001);

        // Full rotation with all sources requesting
        pulse_reset();
        for (int i = 0; i < 8; i++) set_data(i, 32'h1000_0000 + i);
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            check("rot_idx", 32'(grant_idx), 32'(k % 8));
            check("rot_valid", 32'(bus_valid), 32'd1);
            check("rot_bus", bus_out, 32'h1000_0000 + (k % 8));
            check("rot_grant", 32'(grant), 32'(8'h01 << (k % 8)));
        end
        check("rot_cnt", 32'(xfer_cnt), 32'd8);
        req = 8'h00;
        step();
        check("rot_end_valid", 32'(bus_valid), 32'd0);
        check("rot_end_cnt", 32'(xfer_cnt), 32'd9);

        // Stall: ptr is 1, req 2 and 5 -> source 2 wins and holds while sink stalls
        req       = 8'h24;
        bus_ready = 1'b0;
        set_data(2, 32'hD00D_0002);
        set_data(5, 32'hD00D_0005);
        step();
        check("stall_grant0", 32'(grant), 32'h04);
        check("stall_bus0", bus_out, 32'hD00D_0002);
        for (int c = 0; c < 5; c++) begin
            set_data(2, 32'hBAD0_0000 + c);
            step();
            check("stall_bus", bus_out, 32'hD00D_0002);
            check("stall_grant", 32'(grant), 32'h04);
            check("stall_valid", 32'(bus_valid), 32'd1);
        end
        bus_ready = 1'b1;
        step();
        check("stall_next_idx", 32'(grant_idx), 32'd5);
        check("stall_next_bus", bus_out, 32'hD00D_0005);
        check("stall_cnt", 32'(xfer_cnt), 32'd10);

        // Lock: ptr is 6, req 1 and 3 -> source 1, then held while locked
        lock = 1'b1;
        req  = 8'h0A;
        set_data(1, 32'h1111_0000);
        set_data(3, 32'h3333_0003);
        step();
        check("lock_first", 32'(grant_idx), 32'd1);
        for (int c = 1; c < 4; c++) begin
            set_data(1, 32'h1111_0000 + c);
            step();
            check("lock_idx", 32'(grant_idx), 32'd1);
            check("lock_bus", bus_out, 32'h1111_0000 + c);
        end
        lock = 1'b0;
        step();
        check("unlock_idx", 32'(grant_idx), 32'd3);
        check("unlock_bus", bus_out, 32'h3333_0003);

        // Asynchronous reset while busy
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus_valid), 32'd0);
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_idx", 32'(grant_idx), 32'd0);
        check("arst_bus", bus_out, 32'd0);
        check("arst_cnt", 32'(xfer_cnt), 32'd0);
        req   = 8'h80;
        set_data(7, 32'h7777_0007);
        rst_n = 1'b1;
        step();
        check("arst_after_idx", 32'(grant_idx), 32'd7);
        check("arst_after_grant", 32'(grant), 32'h80);
        check("arst_after_valid", 32'(bus_valid), 32'd1);

        // First arbitration after reset searches from source 0
        pulse_reset();
        req = 8'h84;
        set_data(2, 32'h2222_0002);
        step();
        check("post_rst_idx", 32'(grant_idx), 32'd2);
        check("post_rst_bus", bus_out, 32'h2222_0002);

        // Counter saturation
        pulse_reset();
        req       = 8'hFF;
        bus_ready = 1'b1;
        step();
        repeat (65534) @(posedge clk);
        #1;
        check("cnt_fffe", 32'(xfer_cnt), 32'h0000_FFFE);
        step();
        check("cnt_ffff", 32'(xfer_cnt), 32'h0000_FFFF);
        repeat (5) @(posedge clk);
        #1;
        check("cnt_sat", 32'(xfer_cnt), 32'h0000_FFFF);
        check("cnt_sat_valid", 32'(bus_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
